// File: rtl/count10_pkg.sv
// Shared types and constants for the BCD count sequencer.
package count10_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_LOAD  = 2'b11
    } cmd_op_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_CLR   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        CLR   = ST_CLR,
        DONE  = ST_DONE
    } state_t;

    // Out-of-range nibbles clamp to the largest legal BCD digit.
    function automatic logic [3:0] bcd_sat(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/count10_seq_ctrl_bcd_digit.sv
// One decade (0-9) counter stage with synchronous clear and ripple carry.
module bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc_in,
    output logic [3:0] q,
    output logic       carry_out
);
    import count10_pkg::*;

    assign carry_out = inc_in & (q == BCD_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc_in) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/count10_seq_ctrl.sv
// Command sequencer for a cascaded BCD up-counter with prescaled tick gating.
//   state | meaning
//   IDLE  | stopped, count holds, waiting for START
//   RUN   | counting prescaled ticks, target compare active
//   PAUSE | stopped mid-run, count and prescaler hold
//   CLR   | one-cycle clear of count and prescaler, commands refused
//   DONE  | target reached, count holds until START or CLEAR
module count10_seq_ctrl #(
    parameter int NUM_DIGITS = 2,
    parameter int PRESCALE   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_in,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [4*NUM_DIGITS-1:0] cmd_data,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    running,
    output logic                    done,
    output logic                    wrapped
);
    import count10_pkg::*;

    localparam int         W        = 4 * NUM_DIGITS;
    localparam logic [7:0] PRESC_TC = 8'(PRESCALE - 1);

    state_t          state, state_nxt;
    cmd_op_t         op;
    logic [7:0]      presc;
    logic [W-1:0]    target, target_sat, count_nxt;
    logic            target_valid;
    logic [NUM_DIGITS:0] carry;
    logic            accept, is_start, is_stop, is_clear, is_load;
    logic            halt, tick_adv, inc, clr_cnt, match;

    assign op        = cmd_op_t'(cmd_op);
    assign cmd_ready = (state != CLR);
    assign running   = (state == RUN);

    assign accept   = cmd_valid & cmd_ready;
    assign is_start = accept & (op == CMD_START);
    assign is_stop  = accept & (op == CMD_STOP);
    assign is_clear = accept & (op == CMD_CLEAR);
    assign is_load  = accept & (op == CMD_LOAD);

    // A STOP/CLEAR landing on a due increment wins and freezes the prescaler too.
    assign halt     = is_stop | is_clear;
    assign tick_adv = (state == RUN) & tick_in & ~halt;
    assign inc      = tick_adv & (presc == PRESC_TC);
    assign clr_cnt  = (state == CLR) | ((state == DONE) & is_start);

    assign carry[0] = inc;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk       (clk),
                .reset     (reset),
                .clr       (clr_cnt),
                .inc_in    (carry[i]),
                .q         (count[4*i +: 4]),
                .carry_out (carry[i+1])
            );

            assign count_nxt[4*i +: 4] = !carry[i] ? count[4*i +: 4] :
                                         (count[4*i +: 4] == BCD_MAX) ? 4'd0 :
                                         count[4*i +: 4] + 4'd1;
            assign target_sat[4*i +: 4] = bcd_sat(cmd_data[4*i +: 4]);
        end
    endgenerate

    // Compares against the target held before this edge, so a same-cycle load is not seen.
    assign match = inc & target_valid & (count_nxt == target);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (is_start)      state_nxt = RUN;
                else if (is_clear) state_nxt = CLR;
            end
            RUN: begin
                if (is_stop)       state_nxt = PAUSE;
                else if (is_clear) state_nxt = CLR;
                else if (match)    state_nxt = DONE;
            end
            PAUSE: begin
                if (is_start)      state_nxt = RUN;
                else if (is_clear) state_nxt = CLR;
            end
            CLR: state_nxt = IDLE;
            DONE: begin
                if (is_start)      state_nxt = RUN;
                else if (is_clear) state_nxt = CLR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            presc        <= 8'd0;
            target       <= '0;
            target_valid <= 1'b0;
            done         <= 1'b0;
            wrapped      <= 1'b0;
        end else begin
            state   <= state_nxt;
            done    <= match;
            wrapped <= carry[NUM_DIGITS];

            if (clr_cnt || inc) begin
                presc <= 8'd0;
            end else if (tick_adv) begin
                presc <= presc + 8'd1;
            end

            if (is_load) begin
                target       <= target_sat;
                target_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/count10_seq_ctrl.md
Name: count10_seq_ctrl

Overview:
- Command-driven sequencer for a chain of NUM_DIGITS cascaded decade (0-9) counters forming a BCD up-counter.
- Accepts START/STOP/CLEAR/LOAD_TARGET commands over a valid/ready handshake.
- Gates counting through a prescaler on an external tick strobe, and signals target match and wrap-around.
- Sits between control logic and the decade-counter datapath.

Parameters:
- NUM_DIGITS, 2: number of cascaded BCD digits; count width is 4*NUM_DIGITS.
- PRESCALE, 1: number of tick_in pulses consumed per count increment; must be 1 to 255.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; state is reset while 0.
- tick_in  in  1  count-enable strobe, sampled each cycle.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  operation: 00 START, 01 STOP, 10 CLEAR, 11 LOAD_TARGET.
- cmd_data  in  4*NUM_DIGITS  BCD target value; used only by LOAD_TARGET.
- count  out  4*NUM_DIGITS  registered BCD count; digit 0 is in bits [3:0].
- running  out  1  high in RUN state.
- done  out  1  one-cycle pulse on target match.
- wrapped  out  1  one-cycle pulse when count rolls from all-9s to all-0s.

Behaviour:
- Reset (async assert, sync release):
  - count = 0, prescaler = 0, target_valid = 0, target = 0, state = IDLE.
  - running = 0, done = 0, wrapped = 0, cmd_ready = 1.
- Handshake: a command is accepted in a cycle where cmd_valid & cmd_ready. cmd_ready = 0 only in CLR state.
- States and transitions:
  - IDLE: START -> RUN; CLEAR -> CLR; STOP ignored.
  - RUN:
    - Each accepted-free cycle with tick_in = 1 increments the prescaler.
    - When the prescaler reaches PRESCALE-1 with tick_in = 1, the prescaler goes to 0 and count increments by 1 (BCD) in the same edge.
    - STOP -> PAUSE; CLEAR -> CLR.
  - PAUSE: count and prescaler hold. START -> RUN (prescaler retained); CLEAR -> CLR.
  - CLR: one cycle; count = 0, prescaler = 0; -> IDLE. target and target_valid are retained.
  - DONE: count holds. START clears count and prescaler to 0 and -> RUN; CLEAR -> CLR.
- LOAD_TARGET:
  - Accepted in IDLE, RUN, PAUSE and DONE; does not change state.
  - Writes target and sets target_valid = 1.
  - Any nibble greater than 9 is stored as 9.
- BCD increment:
  - Each digit counts 0..9; a digit at 9 goes to 0 and carries into the next digit.
  - All-9s -> all-0s asserts wrapped for exactly the cycle in which count shows 0.
- Target match:
  - If target_valid and the incremented value equals target: count updates to target, state -> DONE, done = 1 for that cycle, running = 0.
  - With target = 0, the match occurs on the wrap; wrapped and done assert together.
- Simultaneous events:
  - A STOP or CLEAR accepted in the same cycle as an increment wins; the increment is suppressed and the prescaler does not advance.
  - A LOAD_TARGET in the same cycle as an increment: the match compares against the old target.
- START in RUN is a no-op; STOP in IDLE, DONE or PAUSE is a no-op.
- A reset assertion mid-operation returns the block to reset values immediately, regardless of clk.
- No combinational path from cmd_* or tick_in to any output except through registers. cmd_ready is a decode of state.

Decomposition:
- Shared package count10_pkg holds:
  - typedef cmd_op_t enum: CMD_START, CMD_STOP, CMD_CLEAR, CMD_LOAD.
  - typedef state_t enum: IDLE, RUN, PAUSE, CLR, DONE.
  - constant BCD_MAX = 4'd9.
- Sub-module bcd_digit, instantiated NUM_DIGITS times in a generate loop:
  - Ports: clk, reset, clr, inc_in, q[3:0], carry_out.
  - carry_out = inc_in & (q == 9).

Test Plan (NUM_DIGITS = 2, PRESCALE = 3):
- Drive reset low mid-RUN at count 0x37, between clock edges -> count = 0x00, running = 0, cmd_ready = 1 before the next clk edge.
- START, then tick_in held 1 for 33 cycles -> count steps 0x00, 0x01 ... 0x09, 0x10, 0x11, one increment every 3 cycles; running = 1.
- Run from 0x98 with no target -> 0x99 then 0x00; wrapped high exactly one cycle; done stays 0.
- LOAD_TARGET 0x12, START, tick_in = 1 -> done pulses once as count reaches 0x12; running drops; count holds at 0x12 through 10 more ticks; then START -> count restarts from 0x00.
- STOP in the same cycle as a due increment at count 0x05 -> count stays 0x05, state PAUSE; START with tick_in = 1 -> increment occurs on the next tick (prescaler retained at 2).
- CLEAR while in RUN at 0x44 -> cmd_ready = 0 for one cycle; count = 0x00; a START presented during that cycle is not accepted; target is retained, shown by a later START reaching done at the previously loaded target.
